// File: rtl/store_aligner.sv
// Store-path write aligner: narrows a store value to byte/half/word, positions it on the
// word-aligned write bus with byte enables, and splits word-crossing stores into two beats.
module store_aligner #(
    parameter int unsigned word_size = 32,
    parameter int unsigned addr_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [addr_size-1:0] req_addr,
    input  logic [word_size-1:0] req_data,
    input  logic [1:0]           req_size,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic [3:0]           mem_be,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StSecond
    } state_e;

    state_e                   state_q, state_d;
    logic [addr_size-1:0]     base_q, base_d;
    logic [2*word_size-1:0]   sh_q, sh_d;
    logic [7:0]               be8_q, be8_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic [1:0]               off;
    logic [3:0]               mask;
    logic [word_size-1:0]     data_trunc;
    logic                     size_rsvd;

    // Request decode: lane mask and truncated data for the requested size.
    always_comb begin
        off        = req_addr[1:0];
        mask       = 4'b0000;
        data_trunc = '0;
        size_rsvd  = 1'b0;
        case (req_size)
            2'b00: begin
                mask       = 4'b0001;
                data_trunc = {{(word_size-8){1'b0}}, req_data[7:0]};
            end
            2'b01: begin
                mask       = 4'b0011;
                data_trunc = {{(word_size-16){1'b0}}, req_data[15:0]};
            end
            2'b10: begin
                mask       = 4'b1111;
                data_trunc = req_data;
            end
            default: begin
                size_rsvd = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        sh_d    = sh_q;
        be8_d   = be8_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (size_rsvd) begin
                        err_d = 1'b1;
                    end else begin
                        base_d  = {req_addr[addr_size-1:2], 2'b00};
                        sh_d    = {{word_size{1'b0}}, data_trunc} << {off, 3'b000};
                        be8_d   = {4'b0000, mask} << off;
                        state_d = StFirst;
                    end
                end
            end
            StFirst: begin
                if (mem_ready) begin
                    if (be8_q[7:4] != 4'b0000) begin
                        state_d = StSecond;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StSecond: begin
                if (mem_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus outputs come straight from registered state, so they hold while stalled.
    always_comb begin
        req_ready = (state_q == StIdle);
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        unique case (state_q)
            StFirst: begin
                mem_valid = 1'b1;
                mem_addr  = base_q;
                mem_wdata = sh_q[word_size-1:0];
                mem_be    = be8_q[3:0];
            end
            StSecond: begin
                mem_valid = 1'b1;
                mem_addr  = base_q + addr_size'(4);
                mem_wdata = sh_q[2*word_size-1:word_size];
                mem_be    = be8_q[7:4];
            end
            default: begin
                mem_valid = 1'b0;
            end
        endcase
    end

    assign done = done_q;
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= '0;
            sh_q    <= '0;
            be8_q   <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sh_q    <= sh_d;
            be8_q   <= be8_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Scoreboard bench for store_aligner: directed stores push expected beats/events, a monitor
// pops and compares them as the DUT presents bus handshakes and done/err pulses.
module tb_store_aligner;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    store_aligner #(.word_size(32), .addr_size(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    beat_t beat_q[$];
    logic  ev_q[$];  // 0 = done, 1 = err

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs  = -10;
    int acc_cyc  = -10;
    int stall_cfg = 0;
    int ctr      = 0;
    bit mon_en   = 1'b0;

    logic  stalled = 1'b0;
    beat_t held;
    beat_t got;
    logic  ev;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        checks++;
        failures++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endfunction

    function automatic void push_beat(logic [31:0] a, logic [31:0] w, logic [3:0] b);
        beat_t t;
        t.addr  = a;
        t.wdata = w;
        t.be    = b;
        beat_q.push_back(t);
    endfunction

    // Memory model: holds mem_ready low for stall_cfg cycles at the start of every beat.
    always @(posedge clk) begin
        #2;
        if (mem_valid) begin
            if (ctr < stall_cfg) begin
                mem_ready = 1'b0;
                ctr++;
            end else begin
                mem_ready = 1'b1;
                ctr = 0;
            end
        end else begin
            mem_ready = 1'b1;
            ctr = 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("ready_is_idle", {31'b0, req_ready}, {31'b0, !mem_valid});
            if (!mem_valid) begin
                check("idle_be", {28'b0, mem_be}, 32'h0);
                check("idle_wdata", mem_wdata, 32'h0);
            end
            if (stalled && mem_valid) begin
                check("stall_addr", mem_addr, held.addr);
                check("stall_wdata", mem_wdata, held.wdata);
                check("stall_be", {28'b0, mem_be}, {28'b0, held.be});
            end
            if (mem_valid && mem_ready) begin
                if (beat_q.size() == 0) begin
                    fail_now("unexpected_beat", $sformatf("got addr 0x%08h, required no write",
                                                          mem_addr));
                end else begin
                    got = beat_q.pop_front();
                    check("beat_addr", mem_addr, got.addr);
                    check("beat_wdata", mem_wdata, got.wdata);
                    check("beat_be", {28'b0, mem_be}, {28'b0, got.be});
                end
                last_hs = cyc;
            end
            stalled    = mem_valid && !mem_ready;
            held.addr  = mem_addr;
            held.wdata = mem_wdata;
            held.be    = mem_be;
            if (done || err) begin
                check("done_err_excl", {31'b0, done && err}, 32'h0);
                if (ev_q.size() == 0) begin
                    fail_now("unexpected_event", $sformatf("got done=%0b err=%0b, required none",
                                                           done, err));
                end else begin
                    ev = ev_q.pop_front();
                    check("event_kind", {31'b0, err}, {31'b0, ev});
                    if (done) check("done_latency", cyc, last_hs + 1);
                    if (err) begin
                        check("err_latency", cyc, acc_cyc + 1);
                        check("err_ready", {31'b0, req_ready}, 32'h1);
                    end
                end
            end
            if (req_valid && req_ready) acc_cyc = cyc;
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) fail_now("req_ready_timeout", "got req_ready=0, required 1");
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int n = 0;
        while ((beat_q.size() != 0 || ev_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (beat_q.size() != 0 || ev_q.size() != 0) begin
            fail_now("drain_timeout", $sformatf("got %0d beats/%0d events pending, required 0",
                                                beat_q.size(), ev_q.size()));
            beat_q.delete();
            ev_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", {28'b0, mem_be}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Byte store to lane 3.
        push_beat(32'h100, 32'hA500_0000, 4'b1000);
        ev_q.push_back(1'b0);
        store(32'h103, 32'hFFFF_FFA5, 2'b00);
        drain();

        // Misaligned word store, split.
        push_beat(32'h100, 32'h3344_0000, 4'b1100);
        push_beat(32'h104, 32'h0000_1122, 4'b0011);
        ev_q.push_back(1'b0);
        store(32'h102, 32'h1122_3344, 2'b10);
        drain();

        // Split half store with 3-cycle backpressure on each beat.
        stall_cfg = 3;
        push_beat(32'h100, 32'hEF00_0000, 4'b1000);
        push_beat(32'h104, 32'h0000_00BE, 4'b0001);
        ev_q.push_back(1'b0);
        store(32'h103, 32'h1234_BEEF, 2'b01);
        drain();
        stall_cfg = 0;

        // Wrap-around at the top of the address space.
        push_beat(32'hFFFF_FFFC, 32'hDD00_0000, 4'b1000);
        push_beat(32'h0000_0000, 32'h00AA_BBCC, 4'b0111);
        ev_q.push_back(1'b0);
        store(32'hFFFF_FFFF, 32'hAABB_CCDD, 2'b10);
        drain();

        // Reserved size.
        ev_q.push_back(1'b1);
        store(32'h200, 32'h1234_5678, 2'b11);
        drain();

        // Back-to-back non-split stores.
        push_beat(32'h020, 32'h5678_0000, 4'b1100);
        ev_q.push_back(1'b0);
        push_beat(32'h200, 32'h0000_7700, 4'b0010);
        ev_q.push_back(1'b0);
        push_beat(32'h000, 32'h00AB_CD00, 4'b0110);
        ev_q.push_back(1'b0);
        store(32'h022, 32'hFFFF_5678, 2'b01);
        store(32'h201, 32'h1234_5677, 2'b00);
        store(32'h001, 32'h9999_ABCD, 2'b01);
        drain();

        // Reset while stalled in the second beat: no second write, no done.
        stall_cfg = 5;
        push_beat(32'h100, 32'h3344_0000, 4'b1100);
        store(32'h102, 32'h1122_3344, 2'b10);
        begin
            int n = 0;
            while (beat_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (beat_q.size() != 0) fail_now("first_beat_timeout", "got no beat, required one");
        end
        @(posedge clk);
        #1;
        check("pre_reset_valid", {31'b0, mem_valid}, 32'h1);
        check("pre_reset_addr", mem_addr, 32'h104);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_valid", {31'b0, mem_valid}, 32'h0);
        check("post_reset_be", {28'b0, mem_be}, 32'h0);
        check("post_reset_ready", {31'b0, req_ready}, 32'h1);
        check("post_reset_done", {31'b0, done}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        stall_cfg = 0;

        push_beat(32'h040, 32'hCAFE_F00D, 4'b1111);
        ev_q.push_back(1'b0);
        store(32'h040, 32'hCAFE_F00D, 2'b10);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
